// File: rtl/can_pkg.sv
// Shared definitions for the CAN RX fetch arbiter.
// Covers the FSM encoding, local register map, SJA1000 register numbers and the release command.
package can_pkg;

   typedef enum logic [3:0] {
      IDLE, CPU_ISS, CPU_WAIT, IR_ISS, IR_WAIT, RX_ISS, RX_WAIT, REL_ISS, REL_WAIT
   } arb_state_t;

   localparam logic [1:0] LREG_RXDATA = 2'd0;
   localparam logic [1:0] LREG_STATUS = 2'd1;
   localparam logic [1:0] LREG_CTRL   = 2'd2;
   localparam logic [1:0] LREG_RSVD   = 2'd3;

   localparam logic [7:0] SJA_REG_CMR   = 8'd1;
   localparam logic [7:0] SJA_REG_IR    = 8'd3;
   localparam logic [7:0] SJA_REG_RXBUF = 8'd16;
   localparam logic [3:0] SJA_RX_BYTES  = 4'd13;
   localparam logic [7:0] SJA_CMD_RRB   = 8'h04;

   // SJA1000 registers sit on 32-bit word boundaries of the engine address space
   function automatic logic [31:0] sja_addr(input logic [7:0] reg_num);
      return {22'b0, reg_num, 2'b00};
   endfunction

endpackage

// File: rtl/can_rx_byte_fifo.sv
// Synchronous show-ahead byte FIFO for received CAN frame bytes.
// The head byte is visible on dout whenever the FIFO is not empty.
module can_rx_byte_fifo
   import can_pkg::*;
#(
   parameter int FIFO_DEPTH = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic [7:0] din,
   input  logic       pop,
   output logic [7:0] dout,
   output logic [7:0] count,
   output logic       empty,
   output logic       full
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == 8'd0);
   assign full    = (count == 8'(FIFO_DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally at the power-of-two depth
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= 8'd0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 8'd1;
         else if (!do_push && do_pop) count <= count - 8'd1;
      end
   end

endmodule

// File: rtl/can_rx_fetch_arb.sv
// Arbitrates CPU register access and autonomous SJA1000 RX frame fetches onto one bus-cycle engine.
// Optional macro CAN_RX_IRQ_OUT_EN drives irq_o from FIFO-not-empty or error; otherwise irq_o is 0.
module can_rx_fetch_arb
   import can_pkg::*;
#(
   parameter int FIFO_DEPTH  = 64,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] addr_32b_i,
   input  logic        wren_i,
   input  logic        rden_i,
   input  logic [31:0] din_32b_i,
   output logic [31:0] dout_32b_o,
   output logic        dout_32b_valid_o,
   output logic [31:0] ctl_addr_32b_o,
   output logic        ctl_wren_o,
   output logic        ctl_rden_o,
   output logic [31:0] ctl_din_32b_o,
   input  logic [31:0] ctl_dout_32b_i,
   input  logic        ctl_dout_32b_valid_i,
   input  logic        can_int_n_i,
   output logic        irq_o
);

   localparam int              TMR_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

   logic int_n_s1, int_n_s2;

   logic       cpu_req, local_req, local_rd, local_wr, pt_req, pt_drop;
   logic [1:0] loff;
   logic       unused_addr;

   logic        pend_vld, pend_wr;
   logic [7:0]  pend_reg;
   logic [31:0] pend_din;

   logic fetch_en, err, ovf, ctrl_wr, ctrl_w1c;

   logic [7:0] fifo_dout, fifo_count;
   logic       fifo_push, fifo_pop, fifo_empty, fifo_full;
   logic [8:0] fifo_free;

   arb_state_t       state, state_d;
   logic [7:0]       ctl_reg, reg_d;
   logic [31:0]      ctl_din_r, din_d;
   logic             ctl_wr_r, wr_d;
   logic [3:0]       rx_idx, idx_d;
   logic [TMR_W-1:0] tmr, tmr_d;
   logic             in_wait, err_set, pt_done;
   logic [31:0]      pt_rdata, local_rdata;

   logic [31:0] dout_p1;
   logic        vld_p1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         int_n_s1 <= 1'b1;
         int_n_s2 <= 1'b1;
      end else begin
         int_n_s1 <= can_int_n_i;
         int_n_s2 <= int_n_s1;
      end
   end

   assign cpu_req     = wren_i | rden_i;
   assign loff        = addr_32b_i[3:2];
   assign local_req   = cpu_req && addr_32b_i[10];
   assign local_wr    = local_req && wren_i;
   assign local_rd    = local_req && !wren_i;
   assign pt_req      = cpu_req && !addr_32b_i[10];
   assign pt_drop     = pt_req && pend_vld;
   assign unused_addr = ^{addr_32b_i[31:11], addr_32b_i[1:0]};

   assign ctrl_wr  = local_wr && (loff == LREG_CTRL);
   assign ctrl_w1c = ctrl_wr && din_32b_i[1];
   assign fifo_pop = local_rd && (loff == LREG_RXDATA) && !fifo_empty;
   assign fifo_free = 9'(FIFO_DEPTH) - {1'b0, fifo_count};

   always_comb begin
      local_rdata = 32'h0;
      case (loff)
         LREG_RXDATA: local_rdata = {23'b0, fifo_empty, (fifo_empty ? 8'h00 : fifo_dout)};
         LREG_STATUS: local_rdata = {20'b0, err, ovf, fifo_full, fifo_empty, fifo_count};
         LREG_CTRL:   local_rdata = {31'b0, fetch_en};
         LREG_RSVD:   local_rdata = 32'h0;
         default:     local_rdata = 32'h0;
      endcase
   end

   can_rx_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .din   (ctl_dout_32b_i[7:0]),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   always_comb begin
      state_d    = state;
      reg_d      = ctl_reg;
      din_d      = ctl_din_r;
      wr_d       = ctl_wr_r;
      idx_d      = rx_idx;
      tmr_d      = tmr;
      fifo_push  = 1'b0;
      err_set    = 1'b0;
      pt_done    = 1'b0;
      pt_rdata   = 32'h0;
      ctl_wren_o = 1'b0;
      ctl_rden_o = 1'b0;
      in_wait    = state inside {CPU_WAIT, IR_WAIT, RX_WAIT, REL_WAIT};

      case (state)
         IDLE: begin
            if (pend_vld) begin
               state_d = CPU_ISS;
               reg_d   = pend_reg;
               din_d   = pend_din;
               wr_d    = pend_wr;
            end else if (fetch_en && !int_n_s2 && (fifo_free >= 9'(SJA_RX_BYTES))) begin
               state_d = IR_ISS;
               reg_d   = SJA_REG_IR;
               din_d   = 32'h0;
               wr_d    = 1'b0;
            end
         end
         CPU_ISS, IR_ISS, RX_ISS, REL_ISS: begin
            ctl_wren_o = ctl_wr_r;
            ctl_rden_o = !ctl_wr_r;
            tmr_d      = '0;
            case (state)
               CPU_ISS: state_d = CPU_WAIT;
               IR_ISS:  state_d = IR_WAIT;
               RX_ISS:  state_d = RX_WAIT;
               default: state_d = REL_WAIT;
            endcase
         end
         CPU_WAIT: begin
            if (ctl_dout_32b_valid_i) begin
               pt_done  = 1'b1;
               pt_rdata = ctl_dout_32b_i;
               state_d  = IDLE;
            end
         end
         IR_WAIT: begin
            if (ctl_dout_32b_valid_i) begin
               state_d = ctl_dout_32b_i[0] ? RX_ISS : IDLE;
               reg_d   = SJA_REG_RXBUF;
               idx_d   = 4'd0;
            end
         end
         RX_WAIT: begin
            if (ctl_dout_32b_valid_i) begin
               fifo_push = 1'b1;
               if (rx_idx == SJA_RX_BYTES - 4'd1) begin
                  state_d = REL_ISS;
                  reg_d   = SJA_REG_CMR;
                  din_d   = {24'b0, SJA_CMD_RRB};
                  wr_d    = 1'b1;
               end else begin
                  state_d = RX_ISS;
                  reg_d   = ctl_reg + 8'd1;
                  idx_d   = rx_idx + 4'd1;
               end
            end
         end
         REL_WAIT: begin
            if (ctl_dout_32b_valid_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A timeout abandons whatever was in flight; bytes already pushed stay in the FIFO
      if (in_wait && !ctl_dout_32b_valid_i) begin
         if (tmr == TMR_LAST) begin
            state_d = IDLE;
            err_set = 1'b1;
            if (state == CPU_WAIT) begin
               pt_done  = 1'b1;
               pt_rdata = 32'hFFFF_FFFF;
            end
         end else begin
            tmr_d = tmr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ctl_reg   <= 8'h0;
         ctl_din_r <= 32'h0;
         ctl_wr_r  <= 1'b0;
         rx_idx    <= 4'd0;
         tmr       <= '0;
      end else begin
         state     <= state_d;
         ctl_reg   <= reg_d;
         ctl_din_r <= din_d;
         ctl_wr_r  <= wr_d;
         rx_idx    <= idx_d;
         tmr       <= tmr_d;
      end
   end

   // The pending slot stays occupied until its engine transaction completes or times out
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_vld <= 1'b0;
         pend_wr  <= 1'b0;
         pend_reg <= 8'h0;
         pend_din <= 32'h0;
         fetch_en <= 1'b0;
         err      <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         if (pt_done) pend_vld <= 1'b0;
         if (pt_req && !pend_vld) begin
            pend_vld <= 1'b1;
            pend_wr  <= wren_i;
            pend_reg <= addr_32b_i[9:2];
            pend_din <= din_32b_i;
         end
         if (ctrl_wr) fetch_en <= din_32b_i[0];
         if (err_set)       err <= 1'b1;
         else if (ctrl_w1c) err <= 1'b0;
         if (pt_drop)       ovf <= 1'b1;
         else if (ctrl_w1c) ovf <= 1'b0;
      end
   end

   // Response stage: engine completion wins over a local or dropped request in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         dout_p1 <= 32'h0;
      end else begin
         vld_p1 <= pt_done | local_req | pt_drop;
         if (pt_done)                   dout_p1 <= pt_rdata;
         else if (local_rd)             dout_p1 <= local_rdata;
         else if (local_wr || pt_drop)  dout_p1 <= 32'h0;
      end
   end

   assign dout_32b_o       = dout_p1;
   assign dout_32b_valid_o = vld_p1;
   assign ctl_addr_32b_o   = sja_addr(ctl_reg);
   assign ctl_din_32b_o    = ctl_din_r;

`ifdef CAN_RX_IRQ_OUT_EN
   logic irq_r;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) irq_r <= 1'b0;
      else        irq_r <= !fifo_empty | err;
   end
   assign irq_o = irq_r;
`else
   assign irq_o = 1'b0;
`endif

endmodule
